// File: rtl/cpu_control_unit.sv
// Multi-cycle fetch/decode/execute/mem/writeback control FSM for the 8-bit RISC CPU.
// Define CU_TIMEOUT_EN to halt with a fault after TIMEOUT_CYCLES of unanswered memory handshake.
module cpu_control_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        pc_inc,
  output logic        pc_load,
  output logic [7:0]  pc_target,
  output logic [1:0]  rd_sel,
  output logic [1:0]  rs_sel,
  output logic [7:0]  imm,
  output logic [3:0]  alu_op,
  output logic        alu_src_imm,
  input  logic        alu_zero,
  output logic        reg_we,
  output logic        wb_sel_mem,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        zero_q,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state
);
  localparam int unsigned IR_W   = 16;
  localparam int unsigned WAIT_W = 8;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_MEM       = 3'd3,
    S_WRITEBACK = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h9;
  localparam logic [3:0] OP_LD  = 4'hA;
  localparam logic [3:0] OP_ST  = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_CMP = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t          state_q;
  state_t          state_d;
  logic [IR_W-1:0] ir_q;
  logic [3:0]      opcode;
  logic [3:0]      alu_op_dec;
  logic            ir_ld;
  logic            zero_ld;
  logic            timeout_hit;

  assign opcode    = ir_q[15:12];
  assign rd_sel    = ir_q[11:10];
  assign rs_sel    = ir_q[9:8];
  assign imm       = ir_q[7:0];
  assign pc_target = ir_q[7:0];
  assign state     = state_q;
  assign halted    = (state_q == S_HALT);

  // ALU select for the instruction held in IR; non-ALU opcodes select 0.
  always_comb begin
    alu_op_dec = 4'h0;
    case (opcode)
      4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: alu_op_dec = opcode;
      OP_LDI:  alu_op_dec = 4'hF;
      OP_CMP:  alu_op_dec = 4'h2;
      default: alu_op_dec = 4'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    ir_ld       = 1'b0;
    zero_ld     = 1'b0;
    imem_req    = 1'b0;
    pc_inc      = 1'b0;
    pc_load     = 1'b0;
    alu_op      = 4'h0;
    alu_src_imm = 1'b0;
    reg_we      = 1'b0;
    wb_sel_mem  = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) begin
          ir_ld   = 1'b1;
          pc_inc  = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = S_EXECUTE;
      S_EXECUTE: begin
        alu_op      = alu_op_dec;
        alu_src_imm = (opcode == OP_LDI);
        case (opcode)
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
            zero_ld = 1'b1;
            state_d = S_WRITEBACK;
          end
          OP_LDI:        state_d = S_WRITEBACK;
          OP_LD, OP_ST:  state_d = S_MEM;
          OP_JMP: begin
            pc_load = 1'b1;
            state_d = S_FETCH;
          end
          OP_JZ: begin
            pc_load = zero_q;
            state_d = S_FETCH;
          end
          OP_CMP: begin
            zero_ld = 1'b1;
            state_d = S_FETCH;
          end
          OP_HLT:  state_d = S_HALT;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = (opcode == OP_ST);
        if (dmem_ready) state_d = (opcode == OP_LD) ? S_WRITEBACK : S_FETCH;
      end
      S_WRITEBACK: begin
        reg_we      = 1'b1;
        wb_sel_mem  = (opcode == OP_LD);
        alu_op      = alu_op_dec;
        alu_src_imm = (opcode == OP_LDI);
        state_d     = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    if (timeout_hit) state_d = S_HALT;
    // Reset silences every strobe, whatever state the register still holds.
    if (rst) begin
      imem_req = 1'b0;
      pc_inc   = 1'b0;
      pc_load  = 1'b0;
      reg_we   = 1'b0;
      dmem_req = 1'b0;
      dmem_we  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir_q   <= '0;
      zero_q <= 1'b0;
    end else begin
      if (ir_ld)   ir_q   <= instr;
      if (zero_ld) zero_q <= alu_zero;
    end
  end

`ifdef CU_TIMEOUT_EN
  logic [WAIT_W-1:0] wait_cnt;
  logic              waiting;

  // A handshake is pending when a request is out and its ready has not come back.
  assign waiting     = ((state_q == S_FETCH) && !imem_ready) ||
                       ((state_q == S_MEM) && !dmem_ready);
  assign timeout_hit = waiting && (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      fault    <= 1'b0;
    end else begin
      wait_cnt <= waiting ? wait_cnt + WAIT_W'(1) : '0;
      if (timeout_hit) fault <= 1'b1;
    end
  end
`else
  logic unused_timeout;

  assign timeout_hit    = 1'b0;
  assign fault          = 1'b0;
  assign unused_timeout = ^WAIT_W'(TIMEOUT_CYCLES);
`endif

endmodule

// File: tb/tb_cpu_control_unit.sv
// Randomized bench for cpu_control_unit: a per-instruction cycle schedule model drives
// inputs and predicts outputs, compared every cycle on the falling edge.
module tb_cpu_control_unit;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] instr;
  logic        imem_req, imem_ready, pc_inc, pc_load;
  logic [7:0]  pc_target, imm;
  logic [1:0]  rd_sel, rs_sel;
  logic [3:0]  alu_op;
  logic        alu_src_imm, alu_zero, reg_we, wb_sel_mem;
  logic        dmem_req, dmem_we, dmem_ready;
  logic        zero_q, halted, fault;
  logic [2:0]  state;

  cpu_control_unit #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .instr(instr),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .pc_inc(pc_inc), .pc_load(pc_load), .pc_target(pc_target),
    .rd_sel(rd_sel), .rs_sel(rs_sel), .imm(imm),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .alu_zero(alu_zero),
    .reg_we(reg_we), .wb_sel_mem(wb_sel_mem),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .zero_q(zero_q), .halted(halted), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs that cycle must show.
  typedef struct {
    logic        rst;
    logic [15:0] instr;
    logic        imem_ready, dmem_ready, alu_zero;
    logic        chk_regs, chk_alu, chk_src, chk_wb;
    logic [2:0]  state;
    logic        imem_req, pc_inc, pc_load, reg_we, wb_sel_mem, dmem_req, dmem_we;
    logic [3:0]  alu_op;
    logic        alu_src_imm, zero_q, halted, fault;
    logic [15:0] ir;
  } cyc_t;

  cyc_t        sched[$];
  cyc_t        cur;
  bit          cur_valid = 1'b0;
  int          n_chk = 0;
  int          n_pass = 0;
  logic        zq = 1'b0;
  logic        mfault = 1'b0;
  logic [15:0] mir = 16'h0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at %0t: got %h want %h", nm, $time, act, exp);
  endtask

  function automatic logic [3:0] exp_alu(input logic [3:0] op);
    if (op >= 4'h1 && op <= 4'h8) return op;
    if (op == 4'h9) return 4'hF;
    if (op == 4'hE) return 4'h2;
    return 4'h0;
  endfunction

  // Idle cycle: irrelevant inputs randomized, no strobes, registers as the model holds them.
  function automatic cyc_t blank();
    cyc_t r;
    r.rst = 1'b0; r.instr = 16'($urandom);
    r.imem_ready = 1'($urandom); r.dmem_ready = 1'($urandom); r.alu_zero = 1'($urandom);
    r.chk_regs = 1'b1; r.chk_alu = 1'b0; r.chk_src = 1'b0; r.chk_wb = 1'b0;
    r.state = 3'd0; r.imem_req = 1'b0; r.pc_inc = 1'b0; r.pc_load = 1'b0;
    r.reg_we = 1'b0; r.wb_sel_mem = 1'b0; r.dmem_req = 1'b0; r.dmem_we = 1'b0;
    r.alu_op = 4'h0; r.alu_src_imm = 1'b0;
    r.zero_q = zq; r.halted = 1'b0; r.fault = mfault; r.ir = mir;
    return r;
  endfunction

  task automatic push_fetch_wait();
    cyc_t r;
    r = blank(); r.imem_ready = 1'b0; r.imem_req = 1'b1;
    sched.push_back(r);
  endtask

  task automatic gen_instr(input logic [15:0] ins, input int fwait, input int mwait,
                           input logic az, input logic abort_mem);
    cyc_t r;
    logic [3:0] op;
    op = ins[15:12];
    for (int i = 0; i < fwait; i++) push_fetch_wait();
    r = blank(); r.instr = ins; r.imem_ready = 1'b1; r.imem_req = 1'b1; r.pc_inc = 1'b1;
    sched.push_back(r);
    mir = ins;
    r = blank(); r.state = 3'd1; sched.push_back(r);
    r = blank(); r.state = 3'd2; r.alu_zero = az;
    r.chk_alu = 1'b1; r.chk_src = 1'b1; r.alu_op = exp_alu(op); r.alu_src_imm = (op == 4'h9);
    r.pc_load = (op == 4'hC) || ((op == 4'hD) && zq);
    sched.push_back(r);
    if ((op >= 4'h1 && op <= 4'h8) || op == 4'hE) zq = az;
    if (op == 4'hA || op == 4'hB) begin
      for (int i = 0; i < mwait; i++) begin
        r = blank(); r.state = 3'd3; r.dmem_ready = 1'b0;
        r.dmem_req = 1'b1; r.dmem_we = (op == 4'hB);
        sched.push_back(r);
      end
      if (abort_mem) return;
      r = blank(); r.state = 3'd3; r.dmem_ready = 1'b1;
      r.dmem_req = 1'b1; r.dmem_we = (op == 4'hB);
      sched.push_back(r);
    end
    if (op >= 4'h1 && op <= 4'hA) begin
      r = blank(); r.state = 3'd4; r.reg_we = 1'b1;
      r.chk_wb = 1'b1; r.wb_sel_mem = (op == 4'hA);
      r.chk_alu = 1'b1; r.alu_op = exp_alu(op);
      sched.push_back(r);
    end
    if (op == 4'hF) begin
      for (int i = 0; i < 20; i++) begin
        r = blank(); r.state = 3'd5; r.halted = 1'b1; sched.push_back(r);
      end
    end
  endtask

  // Reset cycles; a ready on the last one must be ignored.
  task automatic add_rst(input int n);
    cyc_t r;
    r = blank(); r.rst = 1'b1; r.chk_regs = 1'b0; sched.push_back(r);
    zq = 1'b0; mfault = 1'b0; mir = 16'h0;
    for (int i = 1; i < n; i++) begin
      r = blank(); r.rst = 1'b1; sched.push_back(r);
    end
    sched[$].imem_ready = 1'b1;
    sched[$].dmem_ready = 1'b1;
  endtask

  task automatic run_q();
    while (sched.size() > 0) begin
      cur = sched.pop_front();
      rst = cur.rst; instr = cur.instr; imem_ready = cur.imem_ready;
      dmem_ready = cur.dmem_ready; alu_zero = cur.alu_zero;
      cur_valid = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  function automatic int count_dreq();
    int c = 0;
    foreach (sched[i]) if (sched[i].dmem_req) c++;
    return c;
  endfunction

  function automatic int count_we();
    int c = 0;
    foreach (sched[i]) if (sched[i].reg_we) c++;
    return c;
  endfunction

  always @(negedge clk) begin
    if (cur_valid) begin
      if (cur.chk_regs) begin
        chk("state", 16'(state), 16'(cur.state));
        chk("halted", 16'(halted), 16'(cur.halted));
        chk("zero_q", 16'(zero_q), 16'(cur.zero_q));
        chk("fault", 16'(fault), 16'(cur.fault));
        chk("rd_sel", 16'(rd_sel), 16'(cur.ir[11:10]));
        chk("rs_sel", 16'(rs_sel), 16'(cur.ir[9:8]));
        chk("imm", 16'(imm), 16'(cur.ir[7:0]));
        chk("pc_target", 16'(pc_target), 16'(cur.ir[7:0]));
      end
      chk("imem_req", 16'(imem_req), 16'(cur.imem_req));
      chk("pc_inc", 16'(pc_inc), 16'(cur.pc_inc));
      chk("pc_load", 16'(pc_load), 16'(cur.pc_load));
      chk("reg_we", 16'(reg_we), 16'(cur.reg_we));
      chk("dmem_req", 16'(dmem_req), 16'(cur.dmem_req));
      chk("dmem_we", 16'(dmem_we), 16'(cur.dmem_we));
      if (cur.chk_wb)  chk("wb_sel_mem", 16'(wb_sel_mem), 16'(cur.wb_sel_mem));
      if (cur.chk_alu) chk("alu_op", 16'(alu_op), 16'(cur.alu_op));
      if (cur.chk_src) chk("alu_src_imm", 16'(alu_src_imm), 16'(cur.alu_src_imm));
    end
  end

  initial begin
    rst = 1'b1; instr = 16'h0; imem_ready = 1'b0; dmem_ready = 1'b0; alu_zero = 1'b0;
    @(posedge clk); #1;
    add_rst(3); run_q();

    // LDI R2,#5A: accept, decode, execute, writeback.
    gen_instr(16'h9A5A, 0, 0, 1'b0, 1'b0);
    chk("pin_ldi_len", 16'(sched.size()), 16'd4);
    chk("pin_ldi_pcinc", 16'(sched[0].pc_inc), 16'd1);
    chk("pin_ldi_aluop", 16'(sched[2].alu_op), 16'hF);
    chk("pin_ldi_src", 16'(sched[2].alu_src_imm), 16'd1);
    chk("pin_ldi_imm", 16'(sched[2].ir[7:0]), 16'h5A);
    chk("pin_ldi_we", 16'(sched[3].reg_we), 16'd1);
    chk("pin_ldi_wbsel", 16'(sched[3].wb_sel_mem), 16'd0);
    run_q();

    // SUB sets the flag, JZ then jumps; CMP clears it, JZ then falls through.
    gen_instr(16'h2600, 1, 0, 1'b1, 1'b0);
    chk("pin_sub_aluop", 16'(sched[3].alu_op), 16'h2);
    run_q();
    gen_instr(16'hD040, 0, 0, 1'b0, 1'b0);
    chk("pin_jz_taken", 16'(sched[$].pc_load), 16'd1);
    run_q();
    gen_instr(16'hE100, 2, 0, 1'b0, 1'b0);
    run_q();
    gen_instr(16'hD040, 0, 0, 1'b1, 1'b0);
    chk("pin_jz_not", 16'(sched[$].pc_load), 16'd0);
    run_q();

    // LD with a 3-cycle data wait, then ST.
    gen_instr(16'hA010, 0, 3, 1'b0, 1'b0);
    chk("pin_ld_dreq", 16'(count_dreq()), 16'd4);
    chk("pin_ld_wbsel", 16'(sched[$].wb_sel_mem), 16'd1);
    run_q();
    gen_instr(16'hB410, 1, 1, 1'b0, 1'b0);
    chk("pin_st_we", 16'(count_we()), 16'd0);
    chk("pin_st_dwe", 16'(sched[$].dmem_we), 16'd1);
    run_q();

    for (int k = 0; k < 70; k++) begin
      gen_instr({4'($urandom_range(0, 14)), 12'($urandom)},
                int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
                1'($urandom), 1'b0);
      run_q();
    end

    // Reset lands mid-MEM with the flag set.
    gen_instr(16'hE000, 0, 0, 1'b1, 1'b0);
    gen_instr(16'hA123, 0, 2, 1'b0, 1'b1);
    add_rst(2);
    gen_instr(16'h1500, 0, 0, 1'b0, 1'b0);
    run_q();

    // Halt, stay halted, recover through reset.
    gen_instr(16'hF000, 0, 0, 1'b0, 1'b0);
    add_rst(2);
    gen_instr(16'h3700, 0, 0, 1'b1, 1'b0);
    run_q();

    // Fetch handshake that never completes.
`ifdef CU_TIMEOUT_EN
    for (int i = 0; i < 16; i++) push_fetch_wait();
    mfault = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc_t r;
      r = blank(); r.state = 3'd5; r.halted = 1'b1; sched.push_back(r);
    end
`else
    for (int i = 0; i < 100; i++) push_fetch_wait();
`endif
    add_rst(2);
    gen_instr(16'h8C33, 0, 0, 1'b0, 1'b0);
    run_q();

    cur_valid = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
